alu_accumulator_core: RTL and testbench
=======================================

// Module: alu_accumulator_core
// PURPOSE
//  Parametrised accumulator datapath: WIDTH-bit accumulator (ACC), NREG-entry register file, and a registered ALU.
//  Adds add/sub/and/or/xor/move ops with C/Z/N/V flags.
//  Commands arrive on a valid/ready handshake; each result returns on a valid/ready response channel.
//  Sits between the pin-level command decoder and the top-level output mux.
// PARAMETERS
//  WIDTH  8  datapath width in bits, >=4
//  NREG   4  register-file entries, power of 2, >=2; IDX_W = $clog2(NREG) (localparam)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      core accepts a command (high only in IDLE)
//  cmd_op     in   3      opcode (see BEHAVIOUR)
//  cmd_idx    in   IDX_W  register-file index (source or destination)
//  cmd_imm    in   WIDTH  immediate for LDI
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer takes the result
//  rsp_data   out  WIDTH  ACC value after the op (STA: value stored)
//  acc_out    out  WIDTH  live ACC contents
//  flags      out  4      {C,Z,N,V}, registered
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; ACC, all R[i], flags, rsp_data = 0; rsp_valid=0; cmd_ready=1 once released.
//  Opcodes:
//    000 LDI  ACC<=imm
//    001 ADD  ACC<=ACC+R
//    010 SUB  ACC<=ACC-R
//    011 AND
//    100 OR
//    101 XOR
//    110 STA  R[idx]<=ACC
//    111 LDA  ACC<=R[idx]
//    R = R[cmd_idx] latched in FETCH.
//  FSM: IDLE -> FETCH -> EXEC -> DONE -> IDLE.
//    IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op/idx/imm; go to FETCH.
//    FETCH: operand register <= R[idx].
//    EXEC: compute, write ACC or R[idx], update flags, rsp_data.
//    DONE: rsp_valid=1. Hold rsp_data and flags stable until rsp_ready=1, then return to IDLE.
//  Latency: rsp_valid rises 3 cycles after the accept edge; 4 cycles minimum per command.
//  cmd_ready=0 outside IDLE; cmd_valid there is ignored, no queueing.
//  Arithmetic is modulo 2^WIDTH. SUB is computed as ACC + ~R + 1.
//  Flags:
//    ADD: C = carry out; V = signed overflow.
//    SUB: C = carry out (1 = no borrow, ACC>=R unsigned); V = signed overflow.
//    AND/OR/XOR: C=0, V=0.
//    LDI/LDA: C and V unchanged.
//    Z = (result==0) and N = result[WIDTH-1] for every op except STA.
//    STA leaves all flags and ACC unchanged.
//  STA followed directly by LDA/ADD of the same index reads the new value (write lands in EXEC, next FETCH is >=2 cycles later).
//  rsp_valid and rsp_ready high in the same DONE cycle: response consumed, IDLE next cycle, no extra pulse.
//  Reset asserted mid-FETCH/EXEC/DONE aborts the op; no response is produced, and state is as per reset.
//  Index beyond NREG is impossible (IDX_W sized); no wrap handling is needed.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles, release -> acc_out=0, flags=0000, rsp_valid=0, cmd_ready=1.
//  2 LDI 0x7F; STA R1; ADD R1 -> rsp_data=0xFE, C=0, Z=0, N=1, V=1; rsp_valid rises 3 cycles after accept.
//  3 LDI 0x05; STA R2; SUB R2 -> 0x00, C=1, Z=1, N=0, V=0; then LDI 0x03; SUB R2 -> 0xFE, C=0, N=1.
//  4 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and flags stable; cmd_ready=0; a cmd_valid pulse is dropped.
//  5 Reset mid-EXEC of ADD -> ACC=0, flags=0, rsp_valid never asserts; next command executes normally.
//  6 WIDTH=16, NREG=8: LDI 0xFFFF; STA R7; LDI 0x0001; ADD R7 -> 0x0000, C=1, Z=1, V=0; XOR R7 -> 0xFFFF, C=0, N=1.

Source files
------------

// File: rtl/alu_accumulator_core.sv
// ============================================================================
//  Module  : alu_accumulator_core
//  Brief   : Accumulator datapath with register file, registered ALU, C/Z/N/V
//            flags, and valid/ready command and response channels.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_accumulator_core #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREG)-1:0]  cmd_idx,
  input  logic [WIDTH-1:0]         cmd_imm,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         acc_out,
  output logic [3:0]               flags
);

  localparam int IDX_W = $clog2(NREG);

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_STA = 3'b110;
  localparam logic [2:0] OP_LDA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_op;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_imm;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_acc;
  logic [3:0]         r_flags;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [WIDTH-1:0]   r_rf [NREG];

  logic               w_accept;
  logic               w_exec;
  logic [WIDTH-1:0]   w_b;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign acc_out   = r_acc;
  assign flags     = r_flags;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_exec    = (r_state == S_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SUB reuses the adder as ACC + ~R + 1, so C means "no borrow".
  assign w_b   = (r_op == OP_SUB) ? ~r_opnd : r_opnd;
  assign w_cin = (r_op == OP_SUB);
  assign w_sum = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_res = r_acc;
    w_c   = r_flags[3];
    w_v   = r_flags[0];
    case (r_op)
      OP_LDI: w_res = r_imm;
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_acc[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != r_acc[WIDTH-1]);
      end
      OP_AND: begin
        w_res = r_acc & r_opnd;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_OR: begin
        w_res = r_acc | r_opnd;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_XOR: begin
        w_res = r_acc ^ r_opnd;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
      OP_LDA:  w_res = r_opnd;
      default: w_res = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_LDI;
      r_idx      <= '0;
      r_imm      <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_flags    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_idx <= cmd_idx;
        r_imm <= cmd_imm;
      end
      if (r_state == S_FETCH) begin
        r_opnd <= r_rf[r_idx];
      end
      if (w_exec) begin
        if (r_op == OP_STA) begin
          r_rsp_data <= r_acc;
        end else begin
          r_acc      <= w_res;
          r_flags    <= {w_c, (w_res == '0), w_res[WIDTH-1], w_v};
          r_rsp_data <= w_res;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_exec && (r_op == OP_STA)) begin
      r_rf[r_idx] <= r_acc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_accumulator_core.sv
// ============================================================================
//  Module  : tb_alu_accumulator_core
//  Brief   : Directed self-checking bench for an 8-bit/4-entry and a
//            16-bit/8-entry instance of alu_accumulator_core.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_accumulator_core;

  localparam logic [2:0] LDI = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, STA = 3'b110, LDA = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_cmd_valid = 1'b0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 1'b1;
  logic [2:0]  a_cmd_op = '0;
  logic [1:0]  a_cmd_idx = '0;
  logic [7:0]  a_cmd_imm = '0, a_rsp_data, a_acc;
  logic [3:0]  a_flags;

  logic        b_cmd_valid = 1'b0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 1'b1;
  logic [2:0]  b_cmd_op = '0;
  logic [2:0]  b_cmd_idx = '0;
  logic [15:0] b_cmd_imm = '0, b_rsp_data, b_acc;
  logic [3:0]  b_flags;

  alu_accumulator_core #(.WIDTH(8), .NREG(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_idx(a_cmd_idx), .cmd_imm(a_cmd_imm),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .acc_out(a_acc), .flags(a_flags)
  );

  alu_accumulator_core #(.WIDTH(16), .NREG(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .cmd_idx(b_cmd_idx), .cmd_imm(b_cmd_imm),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .acc_out(b_acc), .flags(b_flags)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the 8-bit instance and consume its response.
  // lat counts edges from the accept edge (=1) until rsp_valid is seen.
  task automatic cmd8(input string tag, input logic [2:0] op, input logic [1:0] idx,
                      input logic [7:0] imm, input logic [7:0] exp_data,
                      input logic [3:0] exp_flags);
    int lat;
    chk({tag, "_cmd_ready"}, {31'd0, a_cmd_ready}, 32'd1);
    a_cmd_valid = 1'b1; a_cmd_op = op; a_cmd_idx = idx; a_cmd_imm = imm; a_rsp_ready = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_rsp_valid"}, {31'd0, a_rsp_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, a_rsp_data}, {24'd0, exp_data});
    chk({tag, "_flags"}, {28'd0, a_flags},    {28'd0, exp_flags});
    chk({tag, "_latency"}, lat, 32'd3);
    tick();
    chk({tag, "_rsp_done"}, {30'd0, a_rsp_valid, a_cmd_ready}, 32'd1);
  endtask

  task automatic cmd16(input string tag, input logic [2:0] op, input logic [2:0] idx,
                       input logic [15:0] imm, input logic [15:0] exp_data,
                       input logic [3:0] exp_flags);
    int lat;
    b_cmd_valid = 1'b1; b_cmd_op = op; b_cmd_idx = idx; b_cmd_imm = imm; b_rsp_ready = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_rsp_valid"}, {31'd0, b_rsp_valid}, 32'd1);
    chk({tag, "_data"},  {16'd0, b_rsp_data}, {16'd0, exp_data});
    chk({tag, "_flags"}, {28'd0, b_flags},    {28'd0, exp_flags});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // 1: reset held 3 cycles
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_acc",       {24'd0, a_acc},   32'd0);
    chk("rst_flags",     {28'd0, a_flags}, 32'd0);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
    chk("rst16_acc",     {16'd0, b_acc},   32'd0);

    // 2: signed overflow on ADD
    cmd8("ldi7f", LDI, 2'd0, 8'h7F, 8'h7F, 4'b0000);
    cmd8("sta1",  STA, 2'd1, 8'h00, 8'h7F, 4'b0000);
    cmd8("add1",  ADD, 2'd1, 8'h00, 8'hFE, 4'b0011);

    // 3: SUB to zero, then borrow; LDI keeps C/V
    cmd8("ldi05", LDI, 2'd0, 8'h05, 8'h05, 4'b0001);
    cmd8("sta2",  STA, 2'd2, 8'h00, 8'h05, 4'b0001);
    cmd8("sub2a", SUB, 2'd2, 8'h00, 8'h00, 4'b1100);
    cmd8("ldi03", LDI, 2'd0, 8'h03, 8'h03, 4'b1000);
    cmd8("sub2b", SUB, 2'd2, 8'h00, 8'hFE, 4'b0010);

    // logic ops, LDA, and SUB signed overflow
    cmd8("and1",  AND_, 2'd1, 8'h00, 8'h7E, 4'b0000);
    cmd8("or2",   OR_,  2'd2, 8'h00, 8'h7F, 4'b0000);
    cmd8("xor1",  XOR_, 2'd1, 8'h00, 8'h00, 4'b0100);
    cmd8("lda2",  LDA,  2'd2, 8'h00, 8'h05, 4'b0000);
    cmd8("ldi80", LDI,  2'd0, 8'h80, 8'h80, 4'b0010);
    cmd8("sub1v", SUB,  2'd1, 8'h00, 8'h01, 4'b1001);

    // 4: backpressure in DONE with a dropped command pulse
    a_cmd_valid = 1'b1; a_cmd_op = LDI; a_cmd_imm = 8'hA5; a_rsp_ready = 1'b0;
    tick();
    a_cmd_valid = 1'b0;
    tick(); tick();
    chk("bp_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_cmd_valid = (i == 2);
      a_cmd_op    = LDI;
      a_cmd_imm   = 8'h55;
      chk("bp_hold_valid", {31'd0, a_rsp_valid}, 32'd1);
      chk("bp_hold_data",  {24'd0, a_rsp_data},  32'hA5);
      chk("bp_hold_flags", {28'd0, a_flags},     32'hB);
      chk("bp_cmd_ready",  {31'd0, a_cmd_ready}, 32'd0);
      tick();
    end
    a_cmd_valid = 1'b0;
    a_rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, a_cmd_ready}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("bp_dropped_acc",   {24'd0, a_acc},       32'hA5);
    chk("bp_no_extra",      {31'd0, a_rsp_valid}, 32'd0);

    // 5: reset during EXEC of ADD aborts the op
    a_cmd_valid = 1'b1; a_cmd_op = ADD; a_cmd_idx = 2'd1;
    tick();
    a_cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_acc",   {24'd0, a_acc},   32'd0);
    chk("abort_flags", {28'd0, a_flags}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_rsp_valid) seen = 1;
      tick();
    end
    chk("abort_no_rsp", seen, 32'd0);
    cmd8("abort_lda1", LDA, 2'd1, 8'h00, 8'h00, 4'b0100);
    cmd8("abort_ldi",  LDI, 2'd0, 8'h12, 8'h12, 4'b0000);

    // 6: 16-bit, 8-entry instance
    cmd16("w_ldiffff", LDI,  3'd0, 16'hFFFF, 16'hFFFF, 4'b0010);
    cmd16("w_sta7",    STA,  3'd7, 16'h0000, 16'hFFFF, 4'b0010);
    cmd16("w_ldi1",    LDI,  3'd0, 16'h0001, 16'h0001, 4'b0000);
    cmd16("w_add7",    ADD,  3'd7, 16'h0000, 16'h0000, 4'b1100);
    cmd16("w_xor7",    XOR_, 3'd7, 16'h0000, 16'hFFFF, 4'b0010);
    chk("w_acc", {16'd0, b_acc}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
